alu_opb_stage: RTL and testbench
================================

ALU_OPB_STAGE -- requirements
Module: alu_opb_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand data width in bits.
REQ-002 Parameter NSRC, default 4, number of operand-B sources; SELW = max(1, clog2(NSRC)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream presents a selection request.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 in_sel  input  SELW  source index; 0 = rs2, 1 = sign-extended imm, 2 = EX/MEM forward, 3 = MEM/WB forward.
REQ-008 in_src  input  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-009 flush  input  1  synchronous pipeline flush.
REQ-010 out_valid  output  1  out_data/out_err hold a valid operand.
REQ-011 out_ready  input  1  downstream consumes the head operand this cycle.
REQ-012 out_data  output  WIDTH  selected operand B, registered.
REQ-013 out_err  output  1  head operand came from an out-of-range in_sel.
REQ-014 err_cnt  output  16  saturating count of accepted out-of-range selections.

Function
REQ-015 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-016 On push the stage SHALL store in_src[in_sel] if in_sel < NSRC, else zero with err bit set.
REQ-017 The stage SHALL buffer up to 2 entries (skid buffer), in FIFO order, tracked by count 0..2.
REQ-018 in_ready SHALL equal (count != 2), combinational from registered state only, never from in_valid or out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_data/out_err SHALL present the head entry, driven directly from a register.
REQ-020 Latency: request pushed at edge k SHALL appear on out_data at edge k+1 when buffer was empty.
REQ-021 count==1 with simultaneous push and pop: count stays 1, pushed entry becomes head at next edge.
REQ-022 count==2: no push possible; pop moves tail to head, count becomes 1.
REQ-023 count==0 with out_ready high: no pop, no underflow.
REQ-024 Head SHALL remain stable while out_valid && !out_ready.
REQ-025 flush SHALL set count to 0 at next edge, discard same-cycle push and pop, and zero out_data and out_err; err_cnt unaffected.
REQ-026 err_cnt SHALL increment on each push with out-of-range in_sel, saturating at 16'hFFFF.

Reset
REQ-027 While rst_n low: count=0, out_valid=0, out_data=0, out_err=0, err_cnt=0, in_ready=1.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered entries immediately, without waiting for clk.
REQ-029 First push is permitted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_opb_pkg SHALL hold source index constants (SRC_RS2=0, SRC_IMM=1, SRC_FWD_MEM=2, SRC_FWD_WB=3) and default WIDTH.
REQ-031 One combinational sub-module opb_mux_n (parametrised WIDTH, NSRC, returns data and range-error flag) SHALL perform selection; skid buffer and counter live in alu_opb_stage.

Verification
REQ-032 Empty, in_sel=0, rs2=AAAA_AAAA, imm=5555_5555, out_ready=1 -> next cycle out_valid=1, out_data=AAAA_AAAA, out_err=0.
REQ-033 Same sources, in_sel=1 -> out_data=5555_5555; then rs2=1234_5678, fwd_mem=8765_4321, in_sel=2 -> out_data=8765_4321.
REQ-034 out_ready=0, push 1111_1111 then 2222_2222 -> in_ready=0, third push refused; out_ready=1 -> outputs 1111_1111, 2222_2222 in order, in_ready returns 1.
REQ-035 NSRC=4, in_sel=5 not representable; run NSRC=3 with in_sel=3 -> out_data=0, out_err=1, err_cnt=1; 65536 such pushes -> err_cnt=FFFF.
REQ-036 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1, err_cnt unchanged.
REQ-037 count=1, rst_n pulsed low between edges -> out_valid=0 and out_data=0 immediately, before next clk edge.

Source files
------------

// File: rtl/alu_opb_pkg.sv
// Shared constants for the ALU operand-B select stage: source indices,
// default data width and the skid-buffer occupancy encoding.
package alu_opb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_NSRC  = 4;

  localparam int unsigned SRC_RS2     = 0;
  localparam int unsigned SRC_IMM     = 1;
  localparam int unsigned SRC_FWD_MEM = 2;
  localparam int unsigned SRC_FWD_WB  = 3;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_opb_stage_mux.sv
// Combinational N-way operand selector; flags indices with no source.
module opb_mux_n
  import alu_opb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned NSRC  = DEFAULT_NSRC,
  localparam int unsigned SELW = sel_width(NSRC)
) (
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src,
  output logic [WIDTH-1:0]      data,
  output logic                  err
);

  logic hit;

  always_comb begin
    data = '0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) begin
        data = src[i*WIDTH +: WIDTH];
        hit  = 1'b1;
      end
    end
    err = !hit;
  end

endmodule

// File: rtl/alu_opb_stage.sv
// Operand-B select stage: muxes one of NSRC sources into a 2-entry skid
// buffer and counts accepted out-of-range selections.
module alu_opb_stage
  import alu_opb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned NSRC  = DEFAULT_NSRC,
  localparam int unsigned SELW = sel_width(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       in_sel,
  input  logic [NSRC*WIDTH-1:0] in_src,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic [15:0]           err_cnt
);

  occ_e              count_q, count_d;
  logic [WIDTH-1:0]  head_data_q, head_data_d;
  logic              head_err_q, head_err_d;
  logic [WIDTH-1:0]  tail_data_q, tail_data_d;
  logic              tail_err_q, tail_err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]  mux_data;
  logic              mux_err;
  logic              push, pop;

  opb_mux_n #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_mux (
    .sel  (in_sel),
    .src  (in_src),
    .data (mux_data),
    .err  (mux_err)
  );

  assign in_ready  = (count_q != OCC_FULL);
  assign out_valid = (count_q != OCC_EMPTY);
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;
  assign err_cnt   = err_cnt_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    err_cnt_d   = err_cnt_q;

    if (flush) begin
      count_d     = OCC_EMPTY;
      head_data_d = '0;
      head_err_d  = 1'b0;
    end else begin
      case (count_q)
        OCC_EMPTY: begin
          if (push) begin
            head_data_d = mux_data;
            head_err_d  = mux_err;
            count_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Simultaneous push and pop replaces the head in place.
          if (push) begin
            if (pop) begin
              head_data_d = mux_data;
              head_err_d  = mux_err;
            end else begin
              tail_data_d = mux_data;
              tail_err_d  = mux_err;
              count_d     = OCC_FULL;
            end
          end else if (pop) begin
            count_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_data_d = tail_data_q;
            head_err_d  = tail_err_q;
            count_d     = OCC_ONE;
          end
        end
        default: count_d = OCC_EMPTY;
      endcase
    end

    if (push && mux_err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= OCC_EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_opb_stage.sv
// Bench for alu_opb_stage: a 4-source and a 3-source instance share stimulus;
// a queue-based model is compared every cycle, plus directed literal checks.
module tb_alu_opb_stage;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ent_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic [127:0] in_src;
  logic         flush;
  logic         out_ready;

  logic        ir  [2];
  logic        ov  [2];
  logic [31:0] od  [2];
  logic        oe  [2];
  logic [15:0] ec  [2];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  ent_t        mq   [2][$];
  logic [15:0] ecnt [2];
  bit          zh   [2];

  alu_opb_stage #(.WIDTH(32), .NSRC(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir[0]),
    .in_sel    (in_sel),
    .in_src    (in_src),
    .flush     (flush),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .out_data  (od[0]),
    .out_err   (oe[0]),
    .err_cnt   (ec[0])
  );

  alu_opb_stage #(.WIDTH(32), .NSRC(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir[1]),
    .in_sel    (in_sel),
    .in_src    (in_src[95:0]),
    .flush     (flush),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .out_data  (od[1]),
    .out_err   (oe[1]),
    .err_cnt   (ec[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t pick(input int unsigned nsrc, input logic [1:0] sel, input logic [127:0] src);
    ent_t r;
    if (int'(sel) < int'(nsrc)) begin
      r.data = src[int'(sel)*32 +: 32];
      r.err  = 1'b0;
    end else begin
      r.data = '0;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  // Reference model: a bounded FIFO of depth 2 per instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        ecnt[k] = '0;
        zh[k]   = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int unsigned sz;
        bit do_push, do_pop;
        ent_t e;
        sz      = mq[k].size();
        do_push = in_valid && (sz < 2) && !flush;
        do_pop  = (sz > 0) && out_ready && !flush;
        if (flush) begin
          mq[k].delete();
          zh[k] = 1'b1;
        end else begin
          if (do_pop) void'(mq[k].pop_front());
          if (do_push) begin
            e = pick((k == 0) ? 4 : 3, in_sel, in_src);
            mq[k].push_back(e);
            zh[k] = 1'b0;
            if (e.err && ecnt[k] != 16'hFFFF) ecnt[k] = ecnt[k] + 16'd1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.out_valid", k), 32'(ov[k]), 32'(mq[k].size() != 0));
      check($sformatf("d%0d.in_ready", k),  32'(ir[k]), 32'(mq[k].size() != 2));
      check($sformatf("d%0d.err_cnt", k),   32'(ec[k]), 32'(ecnt[k]));
      if (mq[k].size() != 0) begin
        check($sformatf("d%0d.out_data", k), od[k], mq[k][0].data);
        check($sformatf("d%0d.out_err", k),  32'(oe[k]), 32'(mq[k][0].err));
      end else if (zh[k]) begin
        check($sformatf("d%0d.out_data_zero", k), od[k], 32'h0);
        check($sformatf("d%0d.out_err_zero", k),  32'(oe[k]), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int unsigned i, input logic [31:0] v);
    in_src[i*32 +: 32] = v;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_src = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst.out_valid", 32'(ov[0]), 32'h0);
    check("rst.in_ready",  32'(ir[0]), 32'h1);
    check("rst.out_data",  od[0], 32'h0);
    check("rst.err_cnt",   32'(ec[1]), 32'h0);
    rst_n = 1'b1;

    // Source selection, back-to-back with a ready consumer.
    set_src(0, 32'hAAAA_AAAA); set_src(1, 32'h5555_5555);
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 1'b1;
    tick();
    check("sel0.out_valid", 32'(ov[0]), 32'h1);
    check("sel0.out_data",  od[0], 32'hAAAA_AAAA);
    check("sel0.out_err",   32'(oe[0]), 32'h0);
    in_sel = 2'd1;
    tick();
    check("sel1.out_data", od[0], 32'h5555_5555);
    set_src(0, 32'h1234_5678); set_src(2, 32'h8765_4321); in_sel = 2'd2;
    tick();
    check("sel2.out_data", od[0], 32'h8765_4321);
    in_valid = 1'b0;
    tick();
    check("drain.out_valid", 32'(ov[0]), 32'h0);

    // Fill with a stalled consumer, third push refused, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    set_src(0, 32'h1111_1111);
    tick();
    set_src(0, 32'h2222_2222);
    tick();
    check("full.in_ready", 32'(ir[0]), 32'h0);
    set_src(0, 32'h3333_3333);
    tick();
    check("full.head_stable", od[0], 32'h1111_1111);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain1.out_data", od[0], 32'h2222_2222);
    check("drain1.in_ready", 32'(ir[0]), 32'h1);
    tick();
    check("drain2.out_valid", 32'(ov[0]), 32'h0);

    // Asynchronous reset between edges with one entry buffered.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0; set_src(0, 32'hDEAD_BEEF);
    tick();
    in_valid = 1'b0;
    check("pre_rst.out_valid", 32'(ov[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", 32'(ov[0]), 32'h0);
    check("async_rst.out_data",  od[0], 32'h0);
    rst_n = 1'b1;

    // First push right after reset release; out-of-range select on NSRC=3.
    in_valid = 1'b1; in_sel = 2'd3; set_src(3, 32'hCAFE_F00D);
    tick();
    check("oor.d3.out_data", od[1], 32'h0);
    check("oor.d3.out_err",  32'(oe[1]), 32'h1);
    check("oor.d3.err_cnt",  32'(ec[1]), 32'h1);
    check("oor.d4.out_data", od[0], 32'hCAFE_F00D);

    // Flush a full buffer while a (discarded) out-of-range push is offered.
    tick();
    check("flush_pre.in_ready", 32'(ir[1]), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", 32'(ov[1]), 32'h0);
    check("flush.out_data",  od[1], 32'h0);
    check("flush.in_ready",  32'(ir[1]), 32'h1);
    check("flush.err_cnt",   32'(ec[1]), 32'h2);

    // Saturation of the error counter.
    in_valid = 1'b1; in_sel = 2'd3; out_ready = 1'b1;
    repeat (65532) tick();
    check("sat.fffe", 32'(ec[1]), 32'h0000_FFFE);
    tick();
    check("sat.ffff", 32'(ec[1]), 32'h0000_FFFF);
    repeat (3) tick();
    check("sat.hold", 32'(ec[1]), 32'h0000_FFFF);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++) set_src(i, $urandom());
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
